// File: rtl/hdmi_timing_pkg.sv
// Shared timing constants and control-bundle type for the HDMI transmit stream.
// Holds the 640x480@60 defaults, derived raster totals, sync polarity and
// the control word that travels alongside the pixel read latency.
package hdmi_timing_pkg;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned PIX_W = 8;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;

  // Sum of the four raster segments of one axis.
  function automatic int unsigned span_total(input int unsigned act, input int unsigned front,
                                             input int unsigned sync_w, input int unsigned back);
    return act + front + sync_w + back;
  endfunction

  localparam int unsigned H_TOTAL_DEF = span_total(H_ACTIVE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL_DEF = span_total(V_ACTIVE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

  // Sync pulses are active low.
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  typedef struct packed {
    logic active;
    logic vsync_n;
    logic hsync_n;
    logic frame_first;
    logic line_first;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_BLANK = '{
    active:      1'b0,
    vsync_n:     SYNC_IDLE,
    hsync_n:     SYNC_IDLE,
    frame_first: 1'b0,
    line_first:  1'b0
  };

endpackage

// File: rtl/hdmi_tx_stream_delay_line.sv
// Fixed-depth shift register with synchronous clear to a parameterised value.
// Ports: clk, clear (sync, active high), din[WIDTH], dout[WIDTH] (DEPTH cycles later).
module delay_line #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift chain; clear loads every stage with the idle value.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/hdmi_tx_stream.sv
// HDMI transmit stream: raster timing generator, pixel fetch by x/y address,
// and latency-aligned pixel/sync output toward a TMDS encoder.
// Ports:
//   clk, reset (sync, active high), enable (low parks raster at origin)
//   xaddr/yaddr/rd_en : pixel request (combinational from counters)
//   r/g/b             : pixel data, READ_LATENCY cycles after rd_en
//   de/sync/d0/d1/d2  : registered encoder inputs, sync = {vsync_n, hsync_n}
//   frame_start/line_start : pulses aligned with the first active output pixel
module hdmi_tx_stream
  import hdmi_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT      = H_FRONT_DEF,
  parameter int unsigned H_SYNC       = H_SYNC_DEF,
  parameter int unsigned H_BACK       = H_BACK_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT      = V_FRONT_DEF,
  parameter int unsigned V_SYNC       = V_SYNC_DEF,
  parameter int unsigned V_BACK       = V_BACK_DEF,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] xaddr,
  output logic [CNT_W-1:0] yaddr,
  output logic             rd_en,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output logic             de,
  output logic [1:0]       sync,
  output logic [PIX_W-1:0] d0,
  output logic [PIX_W-1:0] d1,
  output logic [PIX_W-1:0] d2,
  output logic             frame_start,
  output logic             line_start
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_BEG_C  = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END_C  = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] VS_BEG_C  = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END_C  = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             hactive_c;
  logic             vactive_c;
  ctrl_t            ctrl_in;
  ctrl_t            ctrl_dly;

  // Raster counters; disabled or reset parks them at the origin.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_LAST_C) begin
      hcount <= '0;
      vcount <= (vcount == V_LAST_C) ? '0 : vcount + CNT_W'(1);
    end else begin
      hcount <= hcount + CNT_W'(1);
    end
  end

  assign hactive_c = (hcount < H_ACT_C);
  assign vactive_c = (vcount < V_ACT_C);

  // Pixel request straight from the counters.
  assign xaddr = hcount;
  assign yaddr = vcount;
  assign rd_en = enable & hactive_c & vactive_c;

  // Control word for the current counter position; blank while disabled.
  always_comb begin
    ctrl_in = CTRL_BLANK;
    if (enable) begin
      ctrl_in.active      = hactive_c & vactive_c;
      ctrl_in.hsync_n     = (hcount >= HS_BEG_C && hcount < HS_END_C) ? SYNC_ACTIVE : SYNC_IDLE;
      ctrl_in.vsync_n     = (vcount >= VS_BEG_C && vcount < VS_END_C) ? SYNC_ACTIVE : SYNC_IDLE;
      ctrl_in.frame_first = (hcount == '0) && (vcount == '0);
      ctrl_in.line_first  = (hcount == '0) && vactive_c;
    end
  end

  // Control travels with the read latency so it lines up with r/g/b.
  delay_line #(
    .WIDTH       (CTRL_W),
    .DEPTH       (READ_LATENCY),
    .RESET_VALUE (CTRL_BLANK)
  ) u_ctrl_dly (
    .clk   (clk),
    .clear (reset),
    .din   (ctrl_in),
    .dout  (ctrl_dly)
  );

  // Output register: data passes only in the active region.
  always_ff @(posedge clk) begin
    if (reset) begin
      de          <= 1'b0;
      sync        <= {SYNC_IDLE, SYNC_IDLE};
      d0          <= '0;
      d1          <= '0;
      d2          <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      de          <= ctrl_dly.active;
      sync        <= {ctrl_dly.vsync_n, ctrl_dly.hsync_n};
      d0          <= ctrl_dly.active ? b : '0;
      d1          <= ctrl_dly.active ? g : '0;
      d2          <= ctrl_dly.active ? r : '0;
      frame_start <= ctrl_dly.frame_first;
      line_start  <= ctrl_dly.line_first;
    end
  end

endmodule

// File: tb/tb_hdmi_tx_stream.sv
// Self-checking bench for hdmi_tx_stream on a reduced 16x6 raster (25x12 total).
module tb_hdmi_tx_stream;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int RL = 2;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 12
  localparam int FRAME = HT * VT;          // 300

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] xaddr, yaddr;
  logic        rd_en;
  logic [7:0]  r, g, b;
  logic        de;
  logic [1:0]  sync;
  logic [7:0]  d0, d1, d2;
  logic        frame_start, line_start;

  int n_checks = 0;
  int n_fail   = 0;

  hdmi_tx_stream #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .xaddr(xaddr), .yaddr(yaddr), .rd_en(rd_en),
    .r(r), .g(g), .b(b),
    .de(de), .sync(sync), .d0(d0), .d1(d1), .d2(d2),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;

  // Frame RAM model, two-cycle read; idle reads return junk that must be gated off.
  logic        s1_v, s2_v;
  logic [11:0] s1_x, s1_y, s2_x, s2_y;
  always @(posedge clk) begin
    s1_v <= rd_en; s1_x <= xaddr; s1_y <= yaddr;
    s2_v <= s1_v;  s2_x <= s1_x;  s2_y <= s1_y;
  end
  assign r = s2_v ? s2_x[7:0] : 8'hAA;
  assign g = s2_v ? s2_y[7:0] : 8'h55;
  assign b = s2_v ? (s2_x[7:0] ^ s2_y[7:0]) : 8'hC3;

  typedef struct {
    string      name;
    int         h;
    int         v;
    logic       de;
    logic [1:0] sync;
    logic [7:0] d2, d1, d0;
    logic       fs, ls;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input int h, input int v, input logic e, input logic [1:0] s,
                     input logic [7:0] x2, input logic [7:0] x1, input logic [7:0] x0,
                     input logic f, input logic l);
    vec_t t;
    t.name = n; t.h = h; t.v = v; t.de = e; t.sync = s;
    t.d2 = x2; t.d1 = x1; t.d0 = x0; t.fs = f; t.ls = l;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Three reset cycles with enable held high; returns at the release negedge.
  task automatic reset_release();
    @(negedge clk);
    reset = 1'b1; enable = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, de_cnt, ls_cnt, fs_cnt, vs_cnt, hs_cnt, hs_in_vs, vs_first, hs_first;

    // Positions are counter states; output for position k shows k+3 cycles after release.
    add("origin",     0,  0, 1'b1, 2'b11, 8'd0,  8'd0, 8'd0,  1'b1, 1'b1);
    add("fifth_px",   4,  0, 1'b1, 2'b11, 8'd4,  8'd0, 8'd4,  1'b0, 1'b0);
    add("px_7_1",     7,  1, 1'b1, 2'b11, 8'd7,  8'd1, 8'd6,  1'b0, 1'b0);
    add("px_10_3",   10,  3, 1'b1, 2'b11, 8'd10, 8'd3, 8'd9,  1'b0, 1'b0);
    add("last_px",   15,  3, 1'b1, 2'b11, 8'd15, 8'd3, 8'd12, 1'b0, 1'b0);
    add("after_act", 16,  3, 1'b0, 2'b11, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("pre_hs",    17,  3, 1'b0, 2'b11, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("hs_first",  18,  3, 1'b0, 2'b10, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("hs_last",   21,  3, 1'b0, 2'b10, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("post_hs",   22,  3, 1'b0, 2'b11, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("last_line",  0,  5, 1'b1, 2'b11, 8'd0,  8'd5, 8'd5,  1'b0, 1'b1);
    add("v_front",    0,  6, 1'b0, 2'b11, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("vs_first",   0,  8, 1'b0, 2'b01, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("vs_and_hs", 19,  8, 1'b0, 2'b00, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("vs_last",   24,  9, 1'b0, 2'b01, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("post_vs",    0, 10, 1'b0, 2'b11, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("raster_end",24, 11, 1'b0, 2'b11, 8'd0,  8'd0, 8'd0,  1'b0, 1'b0);
    add("frame2",     0, 12, 1'b1, 2'b11, 8'd0,  8'd0, 8'd0,  1'b1, 1'b1);

    // Reset state with enable high: reset wins.
    reset = 1'b1; enable = 1'b1;
    step(1);
    chk("rst de", 32'(de), 32'd0);
    chk("rst sync", 32'(sync), 32'd3);
    chk("rst d0", 32'(d0), 32'd0);
    chk("rst d1", 32'(d1), 32'd0);
    chk("rst d2", 32'(d2), 32'd0);
    chk("rst frame_start", 32'(frame_start), 32'd0);
    chk("rst line_start", 32'(line_start), 32'd0);
    step(2);
    reset = 1'b0;
    #1;
    chk("rel rd_en", 32'(rd_en), 32'd1);
    chk("rel xaddr", 32'(xaddr), 32'd0);
    chk("rel yaddr", 32'(yaddr), 32'd0);

    // Table of single-position probes, each from a fresh reset.
    foreach (vq[i]) begin
      reset_release();
      k = vq[i].v * HT + vq[i].h;
      step(k + 3);
      chk({vq[i].name, " de"},   32'(de),          32'(vq[i].de));
      chk({vq[i].name, " sync"}, 32'(sync),        32'(vq[i].sync));
      chk({vq[i].name, " d2"},   32'(d2),          32'(vq[i].d2));
      chk({vq[i].name, " d1"},   32'(d1),          32'(vq[i].d1));
      chk({vq[i].name, " d0"},   32'(d0),          32'(vq[i].d0));
      chk({vq[i].name, " fs"},   32'(frame_start), 32'(vq[i].fs));
      chk({vq[i].name, " ls"},   32'(line_start),  32'(vq[i].ls));
    end

    // Whole-frame statistics over output cycles 3..302.
    reset_release();
    de_cnt = 0; ls_cnt = 0; fs_cnt = 0; vs_cnt = 0; hs_cnt = 0; hs_in_vs = 0;
    vs_first = -1; hs_first = -1;
    for (int j = 1; j <= FRAME + 3; j++) begin
      step(1);
      if (j >= 3 && j <= FRAME + 2) begin
        if (de) de_cnt++;
        if (line_start) ls_cnt++;
        if (frame_start) fs_cnt++;
        if (!sync[1]) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = j;
          if (!sync[0]) hs_in_vs++;
        end
        if (!sync[0]) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = j;
        end
      end
      if (j == FRAME + 3) chk("frame period fs", 32'(frame_start), 32'd1);
    end
    chk("frame de count", 32'(de_cnt), 32'(HA * VA));
    chk("frame line_start count", 32'(ls_cnt), 32'(VA));
    chk("frame fs count", 32'(fs_cnt), 32'd1);
    chk("vsync low count", 32'(vs_cnt), 32'(VS * HT));
    chk("vsync first cycle", 32'(vs_first), 32'((VA + VF) * HT + 3));
    chk("hsync low count", 32'(hs_cnt), 32'(HS * VT));
    chk("hsync first cycle", 32'(hs_first), 32'(HA + HF + 3));
    chk("hsync during vsync", 32'(hs_in_vs), 32'(HS * VS));

    // Enable drop at (10,2), then re-enable.
    reset_release();
    step(60);
    chk("en xaddr", 32'(xaddr), 32'd10);
    chk("en yaddr", 32'(yaddr), 32'd2);
    enable = 1'b0;
    #1;
    chk("en_low rd_en", 32'(rd_en), 32'd0);
    step(1);
    chk("en_low +1 de", 32'(de), 32'd1);
    chk("en_low +1 d2", 32'(d2), 32'd8);
    step(1);
    chk("en_low +2 d2", 32'(d2), 32'd9);
    step(1);
    chk("en_low +3 de", 32'(de), 32'd0);
    chk("en_low +3 sync", 32'(sync), 32'd3);
    chk("en_low +3 d2", 32'(d2), 32'd0);
    step(7);
    chk("en_low xaddr", 32'(xaddr), 32'd0);
    chk("en_low de", 32'(de), 32'd0);
    enable = 1'b1;
    #1;
    chk("re_en rd_en", 32'(rd_en), 32'd1);
    chk("re_en xaddr", 32'(xaddr), 32'd0);
    chk("re_en yaddr", 32'(yaddr), 32'd0);
    step(3);
    chk("re_en de", 32'(de), 32'd1);
    chk("re_en fs", 32'(frame_start), 32'd1);
    chk("re_en ls", 32'(line_start), 32'd1);
    step(1);
    chk("re_en next d2", 32'(d2), 32'd1);
    chk("re_en next fs", 32'(frame_start), 32'd0);

    // Reset mid-line at (12,4).
    reset_release();
    step(112);
    chk("mid xaddr", 32'(xaddr), 32'd12);
    chk("mid yaddr", 32'(yaddr), 32'd4);
    chk("mid de before", 32'(de), 32'd1);
    reset = 1'b1;
    step(1);
    chk("mid rst de", 32'(de), 32'd0);
    chk("mid rst sync", 32'(sync), 32'd3);
    chk("mid rst d2", 32'(d2), 32'd0);
    chk("mid rst xaddr", 32'(xaddr), 32'd0);
    step(1);
    reset = 1'b0;
    #1;
    chk("mid rel rd_en", 32'(rd_en), 32'd1);
    step(1);
    chk("mid rel +1 de", 32'(de), 32'd0);
    step(1);
    chk("mid rel +2 de", 32'(de), 32'd0);
    chk("mid rel +2 fs", 32'(frame_start), 32'd0);
    step(1);
    chk("mid rel +3 fs", 32'(frame_start), 32'd1);
    chk("mid rel +3 de", 32'(de), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
